// File: rtl/clb_config_loader.sv
// clb_config_loader: serial configuration writer for the CLB fabric.
// It receives a framed bitstream (sync byte, CLB address, config word and even parity),
// MSB first, and commits each verified word into its per-CLB slot on the flat prog bus.
module clb_config_loader #(
  parameter int         NUM_CLB = 4,
  parameter int         CFG_W   = 17,
  parameter int         ADDR_W  = 2,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_bit,
  input  logic                     cfg_valid,
  input  logic                     cfg_clear,
  output logic [NUM_CLB*CFG_W-1:0] prog_bus,
  output logic                     busy,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic                     cfg_done
);

  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);

  typedef enum logic [1:0] {HUNT, ADDR, DATA, PARITY} state_t;

  state_t                          state;
  state_t                          state_next;
  logic [7:0]                      sh;
  logic [7:0]                      sh_shift;
  logic [CNT_W-1:0]                cnt;
  logic [ADDR_W-1:0]               addr_q;
  logic [CFG_W-1:0]                data_q;
  logic [NUM_CLB-1:0][CFG_W-1:0]   slots;
  logic [NUM_CLB-1:0]              mask;
  logic                            frame_end;
  logic                            frame_good;

  // Even parity over the whole frame payload including the parity bit itself.
  function automatic logic parity_ok(input logic [ADDR_W-1:0] a,
                                     input logic [CFG_W-1:0]  d,
                                     input logic              p);
    return (^{a, d, p}) == 1'b0;
  endfunction

  // Unsigned range check; always true when every address maps to a slot.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(NUM_CLB);
  endfunction

  assign sh_shift   = {sh[6:0], cfg_bit};
  // A clear on the same edge wins over the parity bit, so the frame simply vanishes.
  assign frame_end  = cfg_valid && !cfg_clear && (state == PARITY);
  assign frame_good = frame_end && parity_ok(addr_q, data_q, cfg_bit) && addr_in_range(addr_q);
  assign prog_bus   = slots;

  // State register: clear forces the hunt state regardless of cfg_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: advance only on accepted bits; the parity bit returns to HUNT.
  always_comb begin
    state_next = state;
    if (cfg_clear) begin
      state_next = HUNT;
    end else if (cfg_valid) begin
      case (state)
        HUNT:    if (sh_shift == SYNC) state_next = ADDR;
        ADDR:    if (cnt == ADDR_LAST) state_next = DATA;
        DATA:    if (cnt == DATA_LAST) state_next = PARITY;
        PARITY:  state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // Output decode: busy follows the registered state directly.
  always_comb begin
    busy = (state != HUNT);
  end

  // Frame shifters and bit counter; the sync shifter restarts empty after every lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh     <= '0;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (cfg_clear) begin
      sh  <= '0;
      cnt <= '0;
    end else if (cfg_valid) begin
      case (state)
        HUNT: begin
          sh  <= (sh_shift == SYNC) ? 8'h00 : sh_shift;
          cnt <= '0;
        end
        ADDR: begin
          addr_q <= ADDR_W'({addr_q, cfg_bit});
          cnt    <= (cnt == ADDR_LAST) ? '0 : cnt + CNT_W'(1);
        end
        DATA: begin
          data_q <= CFG_W'({data_q, cfg_bit});
          cnt    <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
        end
        default: begin
          sh  <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  // Slot commit, written mask, completion flag and the one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots     <= '0;
      mask      <= '0;
      cfg_done  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (cfg_clear) begin
        slots    <= '0;
        mask     <= '0;
        cfg_done <= 1'b0;
      end else begin
        cfg_done <= &mask;
        if (frame_end) begin
          if (frame_good) begin
            for (int i = 0; i < NUM_CLB; i++) begin
              if (addr_q == ADDR_W'(i)) begin
                slots[i] <= data_q;
                mask[i]  <= 1'b1;
              end
            end
            frame_ok <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed testbench for clb_config_loader (NUM_CLB=4, CFG_W=17, ADDR_W=2, SYNC=A5).
module tb_clb_config_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_clear = 1'b0;
  logic [67:0] prog_bus;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic        cfg_done;

  int tests = 0;
  int fails = 0;
  int ok_seen = 0;
  int err_seen = 0;

  clb_config_loader #(
    .NUM_CLB(4),
    .CFG_W  (17),
    .ADDR_W (2),
    .SYNC   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_bit  (cfg_bit),
    .cfg_valid(cfg_valid),
    .cfg_clear(cfg_clear),
    .prog_bus (prog_bus),
    .busy     (busy),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .cfg_done (cfg_done)
  );

  always #5 clk = ~clk;

  // Running totals of result pulses, sampled once per cycle.
  always @(posedge clk) begin
    if (frame_ok)  ok_seen  <= ok_seen + 1;
    if (frame_err) err_seen <= err_seen + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send the low n bits of v MSB first; optional idle cycles of random length between bits.
  task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int g = 0; g < idle; g++) begin
          @(negedge clk);
          cfg_valid = 1'b0;
          cfg_bit   = 1'($urandom);
          @(posedge clk);
        end
      end
      @(negedge clk);
      cfg_bit   = v[i];
      cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
    end
  endtask

  // Full 28-bit frame; returns 1 time unit after the parity edge.
  task automatic send_frame(input logic [1:0] a, input logic [16:0] d, input logic p,
                            input bit gaps);
    send_bits({4'h0, 8'hA5, a, d, p}, 28, gaps);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (prog_bus !== 68'h0) begin fails++; $display("FAIL reset_prog: got %h want 0", prog_bus); end
    tests++;
    if ({busy, frame_ok, frame_err, cfg_done} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {busy, frame_ok, frame_err, cfg_done});
    end
    tests++;
  endtask

  task automatic test_single_commit();
    send_frame(2'b10, 17'h15555, 1'b0, 1'b0);
    if ({frame_ok, frame_err} !== 2'b10) begin
      fails++; $display("FAIL t1_pulse: got ok/err %b want 10", {frame_ok, frame_err});
    end
    tests++;
    if (prog_bus !== {17'h0, 17'h15555, 17'h0, 17'h0}) begin
      fails++; $display("FAIL t1_prog: got %h want slot2=15555", prog_bus);
    end
    tests++;
    if (prog_bus[50:34] !== 17'h15555) begin
      fails++; $display("FAIL t1_slot2: got %h want 15555", prog_bus[50:34]);
    end
    tests++;
    @(posedge clk); #1;
    if ({frame_ok, cfg_done} !== 2'b00) begin
      fails++; $display("FAIL t1_after: got ok/done %b want 00", {frame_ok, cfg_done});
    end
    tests++;
  endtask

  task automatic test_parity_error();
    send_frame(2'b10, 17'h15555, 1'b1, 1'b0);
    if ({frame_ok, frame_err} !== 2'b01) begin
      fails++; $display("FAIL t2_pulse: got ok/err %b want 01", {frame_ok, frame_err});
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL t2_busy: got %b want 0", busy); end
    tests++;
    if (prog_bus !== {17'h0, 17'h15555, 17'h0, 17'h0}) begin
      fails++; $display("FAIL t2_prog: got %h want unchanged", prog_bus);
    end
    tests++;
    @(posedge clk); #1;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL t2_err_len: got %b want 0", frame_err); end
    tests++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(2'b00, 17'h00001, 1'b1, 1'b1);
    send_frame(2'b01, 17'h1FFFF, 1'b0, 1'b1);
    send_frame(2'b10, 17'h0F0F0, 1'b1, 1'b1);
    if (cfg_done !== 1'b0) begin fails++; $display("FAIL t3_done_early: got %b want 0", cfg_done); end
    tests++;
    send_frame(2'b11, 17'h12345, 1'b1, 1'b1);
    if ({frame_ok, cfg_done} !== 2'b10) begin
      fails++; $display("FAIL t3_last_ok: got ok/done %b want 10", {frame_ok, cfg_done});
    end
    tests++;
    if (prog_bus !== {17'h12345, 17'h0F0F0, 17'h1FFFF, 17'h00001}) begin
      fails++; $display("FAIL t3_prog: got %h want all four words", prog_bus);
    end
    tests++;
    @(posedge clk); #1;
    if ({frame_ok, cfg_done} !== 2'b01) begin
      fails++; $display("FAIL t3_done: got ok/done %b want 01", {frame_ok, cfg_done});
    end
    tests++;
  endtask

  task automatic test_noise_lock();
    int ok0, err0;
    do_reset();
    @(posedge clk); #1;
    ok0  = ok_seen;
    err0 = err_seen;
    // Noise with partial sync prefixes; it ends in zeros so no window straddling the
    // real sync byte can match.
    send_bits({16'h0, 8'h5A, 8'h80}, 16, 1'b0);
    if (busy !== 1'b0) begin fails++; $display("FAIL t4_nolock: got busy %b want 0", busy); end
    tests++;
    send_frame(2'b01, 17'h0ABCD, 1'b1, 1'b0);
    @(posedge clk); #1;
    if (ok_seen - ok0 !== 1 || err_seen - err0 !== 0) begin
      fails++; $display("FAIL t4_count: got ok %0d err %0d want 1 0", ok_seen - ok0, err_seen - err0);
    end
    tests++;
    if (prog_bus !== {17'h0, 17'h0, 17'h0ABCD, 17'h0}) begin
      fails++; $display("FAIL t4_prog: got %h want slot1=0ABCD", prog_bus);
    end
    tests++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(2'b01, 17'h1FFFF, 1'b0, 1'b0);
    send_bits({17'h0, 8'hA5, 2'b11, 5'b10110}, 15, 1'b0);
    if (busy !== 1'b1) begin fails++; $display("FAIL t5_busy_mid: got %b want 1", busy); end
    tests++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({busy, prog_bus} !== {1'b0, 68'h0}) begin
      fails++; $display("FAIL t5_async: got busy %b prog %h want 0 0", busy, prog_bus);
    end
    tests++;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(2'b11, 17'h00003, 1'b0, 1'b0);
    if ({frame_ok, prog_bus} !== {1'b1, 17'h00003, 51'h0}) begin
      fails++; $display("FAIL t5_recommit: got ok %b prog %h want 1 slot3=3", frame_ok, prog_bus);
    end
    tests++;
  endtask

  task automatic test_clear_at_parity();
    do_reset();
    send_frame(2'b00, 17'h00001, 1'b1, 1'b0);
    send_frame(2'b01, 17'h1FFFF, 1'b0, 1'b0);
    send_frame(2'b10, 17'h0F0F0, 1'b1, 1'b0);
    send_frame(2'b11, 17'h12345, 1'b1, 1'b0);
    @(posedge clk); #1;
    if (cfg_done !== 1'b1) begin fails++; $display("FAIL t6_done_set: got %b want 1", cfg_done); end
    tests++;
    // Everything but the parity bit of a frame to slot 2 (0x00111 + addr 10 -> p=0).
    send_bits({5'h0, 8'hA5, 2'b10, 17'h00111}, 27, 1'b0);
    @(negedge clk);
    cfg_bit   = 1'b0;
    cfg_valid = 1'b1;
    cfg_clear = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    if ({frame_ok, frame_err, busy, cfg_done} !== 4'b0000) begin
      fails++; $display("FAIL t6_flags: got ok/err/busy/done %b want 0000",
                        {frame_ok, frame_err, busy, cfg_done});
    end
    tests++;
    if (prog_bus !== 68'h0) begin fails++; $display("FAIL t6_prog: got %h want 0", prog_bus); end
    tests++;
    @(posedge clk); #1;
    if ({frame_ok, frame_err, cfg_done} !== 3'b000) begin
      fails++; $display("FAIL t6_after: got ok/err/done %b want 000", {frame_ok, frame_err, cfg_done});
    end
    tests++;
    send_frame(2'b00, 17'h00001, 1'b1, 1'b0);
    if ({frame_ok, prog_bus} !== {1'b1, 51'h0, 17'h00001}) begin
      fails++; $display("FAIL t6_resume: got ok %b prog %h want 1 slot0=1", frame_ok, prog_bus);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_parity_error();
    test_back_to_back();
    test_noise_lock();
    test_reset_mid_frame();
    test_clear_at_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
